// File: rtl/pr_skid_stage_pkg.sv
// Shared pipeline-register package: stage state encoding and default widths.
package pr_skid_stage_pkg;

   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_CTRL_WIDTH = 24;

   // Encoding doubles as the held-word count.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_BUSY  = 2'd1,
      ST_FULL  = 2'd2
   } skid_state_t;

endpackage

// File: rtl/pr_skid_stage_slot.sv
// One held entry: valid + control + payload register with load, drop and flush-clear.
// Clear and drop zero valid/ctrl only; payload keeps its stale value.
module pr_skid_slot
   import pr_skid_stage_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int CTRL_WIDTH = DEF_CTRL_WIDTH
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  CLEAR,
   input  logic                  LOAD,
   input  logic                  DROP,
   input  logic [DATA_WIDTH-1:0] LOAD_DATA,
   input  logic [CTRL_WIDTH-1:0] LOAD_CTRL,
   output logic                  VALID,
   output logic [DATA_WIDTH-1:0] DATA,
   output logic [CTRL_WIDTH-1:0] CTRL
);

   // Entry register; clear beats load beats drop.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         VALID <= 1'b0;
         DATA  <= '0;
         CTRL  <= '0;
      end else if (CLEAR) begin
         VALID <= 1'b0;
         CTRL  <= '0;
      end else if (LOAD) begin
         VALID <= 1'b1;
         DATA  <= LOAD_DATA;
         CTRL  <= LOAD_CTRL;
      end else if (DROP) begin
         VALID <= 1'b0;
         CTRL  <= '0;
      end
   end

endmodule

// File: rtl/pr_skid_stage.sv
// Pipeline register stage with optional skid entry.
// Macro PR_SKID_STAGE_SKID_EN: defined -> main + skid entries, registered IN_READY;
// undefined -> single entry, IN_READY = !OUT_VALID || OUT_READY.
module pr_skid_stage
   import pr_skid_stage_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int CTRL_WIDTH = DEF_CTRL_WIDTH
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  FLUSH,
   input  logic                  IN_VALID,
   output logic                  IN_READY,
   input  logic [DATA_WIDTH-1:0] IN_DATA,
   input  logic [CTRL_WIDTH-1:0] IN_CTRL,
   output logic                  OUT_VALID,
   input  logic                  OUT_READY,
   output logic [DATA_WIDTH-1:0] OUT_DATA,
   output logic [CTRL_WIDTH-1:0] OUT_CTRL,
   output logic [1:0]            OCCUPANCY
);

   skid_state_t           state_q, state_d;
   logic                  accept, fire;
   logic                  main_load, main_drop, main_valid;
   logic [DATA_WIDTH-1:0] main_data, main_ld_data;
   logic [CTRL_WIDTH-1:0] main_ctrl, main_ld_ctrl;

   assign fire   = main_valid && OUT_READY;
   assign accept = IN_VALID && IN_READY;

`ifdef PR_SKID_STAGE_SKID_EN
   logic                  in_ready_q;
   logic                  skid_load, skid_drop, skid_valid, main_from_skid;
   logic [DATA_WIDTH-1:0] skid_data;
   logic [CTRL_WIDTH-1:0] skid_ctrl;

   // Ready is registered from the next state so OUT_READY never reaches IN_READY.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) in_ready_q <= 1'b0;
      else       in_ready_q <= (state_d != ST_FULL);
   end

   assign IN_READY     = in_ready_q;
   assign main_ld_data = main_from_skid ? skid_data : IN_DATA;
   assign main_ld_ctrl = main_from_skid ? skid_ctrl : IN_CTRL;
   assign OCCUPANCY    = {skid_valid, main_valid & ~skid_valid};

   pr_skid_slot #(.DATA_WIDTH(DATA_WIDTH), .CTRL_WIDTH(CTRL_WIDTH)) u_skid (
      .CLK       (CLK),
      .RESET     (RESET),
      .CLEAR     (FLUSH),
      .LOAD      (skid_load),
      .DROP      (skid_drop),
      .LOAD_DATA (IN_DATA),
      .LOAD_CTRL (IN_CTRL),
      .VALID     (skid_valid),
      .DATA      (skid_data),
      .CTRL      (skid_ctrl)
   );
`else
   logic rdy_en_q;

   // Holds IN_READY low through reset and until the first edge after release.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) rdy_en_q <= 1'b0;
      else       rdy_en_q <= 1'b1;
   end

   assign IN_READY     = rdy_en_q && (!main_valid || OUT_READY);
   assign main_ld_data = IN_DATA;
   assign main_ld_ctrl = IN_CTRL;
   assign OCCUPANCY    = {1'b0, main_valid};
`endif

   pr_skid_slot #(.DATA_WIDTH(DATA_WIDTH), .CTRL_WIDTH(CTRL_WIDTH)) u_main (
      .CLK       (CLK),
      .RESET     (RESET),
      .CLEAR     (FLUSH),
      .LOAD      (main_load),
      .DROP      (main_drop),
      .LOAD_DATA (main_ld_data),
      .LOAD_CTRL (main_ld_ctrl),
      .VALID     (main_valid),
      .DATA      (main_data),
      .CTRL      (main_ctrl)
   );

   // State register.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) state_q <= ST_EMPTY;
      else       state_q <= state_d;
   end

   // Next state and entry load/drop strobes; flush overrides everything.
   always_comb begin
      state_d   = state_q;
      main_load = 1'b0;
      main_drop = 1'b0;
`ifdef PR_SKID_STAGE_SKID_EN
      skid_load      = 1'b0;
      skid_drop      = 1'b0;
      main_from_skid = 1'b0;
`endif
      if (FLUSH) begin
         state_d = ST_EMPTY;
      end else begin
         case (state_q)
            ST_EMPTY: if (accept) begin
               main_load = 1'b1;
               state_d   = ST_BUSY;
            end
            ST_BUSY: begin
               if (accept && fire) begin
                  main_load = 1'b1;
               end else if (accept) begin
`ifdef PR_SKID_STAGE_SKID_EN
                  skid_load = 1'b1;
                  state_d   = ST_FULL;
`endif
               end else if (fire) begin
                  main_drop = 1'b1;
                  state_d   = ST_EMPTY;
               end
            end
`ifdef PR_SKID_STAGE_SKID_EN
            ST_FULL: if (fire) begin
               main_load      = 1'b1;
               main_from_skid = 1'b1;
               skid_drop      = 1'b1;
               state_d        = ST_BUSY;
            end
`endif
            default: state_d = ST_EMPTY;
         endcase
      end
   end

   assign OUT_VALID = main_valid;
   assign OUT_DATA  = main_data;
   assign OUT_CTRL  = main_valid ? main_ctrl : '0;

endmodule

// File: tb/tb_pr_skid_stage.sv
// Scoreboard bench for pr_skid_stage; expectations follow PR_SKID_STAGE_SKID_EN.
module tb_pr_skid_stage;

   logic        CLK = 1'b0;
   logic        RESET = 1'b1;
   logic        FLUSH = 1'b0;
   logic        IN_VALID = 1'b0;
   logic        IN_READY;
   logic [31:0] IN_DATA = '0;
   logic [23:0] IN_CTRL = '0;
   logic        OUT_VALID;
   logic        OUT_READY = 1'b0;
   logic [31:0] OUT_DATA;
   logic [23:0] OUT_CTRL;
   logic [1:0]  OCCUPANCY;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   logic [55:0] sb[$];
   int pop_cyc[$];
   logic stream_on = 1'b0;
   logic low_seen = 1'b0;

   pr_skid_stage dut (
      .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH),
      .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_DATA(IN_DATA), .IN_CTRL(IN_CTRL),
      .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA), .OUT_CTRL(OUT_CTRL),
      .OCCUPANCY(OCCUPANCY)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: pops the scoreboard on every output transfer; checks ctrl gating on bubbles.
   always @(negedge CLK) begin
      if (!RESET) begin
         if (stream_on && !IN_READY) low_seen = 1'b1;
         if (!OUT_VALID) chk("ctrl_gate", {40'd0, OUT_CTRL}, 64'd0);
         if (OUT_VALID && OUT_READY && !FLUSH) begin
            if (sb.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_word: got data %0h, expected no output", OUT_DATA);
            end else begin
               logic [55:0] e;
               e = sb.pop_front();
               chk("out_data", {32'd0, OUT_DATA}, {32'd0, e[31:0]});
               chk("out_ctrl", {40'd0, OUT_CTRL}, {40'd0, e[55:32]});
               pop_cyc.push_back(cyc);
            end
         end
      end
   end

   task automatic step();
      @(posedge CLK); #1;
   endtask

   // Offer a word until accepted; the scoreboard learns it at the accepting edge.
   task automatic send(input logic [31:0] d, input logic [23:0] c);
      int n;
      IN_VALID = 1'b1; IN_DATA = d; IN_CTRL = c;
      n = 0;
      forever begin
         @(negedge CLK);
         if (IN_READY) begin
            sb.push_back({c, d});
            break;
         end
         n++;
         if (n > 50) begin
            checks++; errors++;
            $display("FAIL send_timeout: word %0h never accepted", d);
            break;
         end
      end
      step();
      IN_VALID = 1'b0;
   endtask

   initial begin
      int base;
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      // Reset state
      #2;
      chk("rst_out_valid", {63'd0, OUT_VALID}, 64'd0);
      chk("rst_in_ready", {63'd0, IN_READY}, 64'd0);
      chk("rst_occ", {62'd0, OCCUPANCY}, 64'd0);
      chk("rst_out_data", {32'd0, OUT_DATA}, 64'd0);
      chk("rst_out_ctrl", {40'd0, OUT_CTRL}, 64'd0);
      #14 RESET = 1'b0;                  // released at t=16, between edges
      @(negedge CLK);
      chk("ready_before_edge", {63'd0, IN_READY}, 64'd0);
      step();
      @(negedge CLK);
      chk("ready_after_edge", {63'd0, IN_READY}, 64'd1);
      step();

      // Single word, one-cycle latency
      OUT_READY = 1'b1;
      send(32'hA5, 24'h000123);
      @(negedge CLK);
      chk("lat_out_valid", {63'd0, OUT_VALID}, 64'd1);
      chk("lat_out_data", {32'd0, OUT_DATA}, 64'hA5);
      chk("lat_occ", {62'd0, OCCUPANCY}, 64'd1);
      step();

      // Back-to-back stream 1..8
      base = pop_cyc.size();
      stream_on = 1'b1;
      for (int i = 1; i <= 8; i++) send(i, 24'h000010 * i);
      stream_on = 1'b0;
      step(); step();
      chk("stream_ready_low", {63'd0, low_seen}, 64'd0);
      chk("stream_count", pop_cyc.size() - base, 64'd8);
      if (pop_cyc.size() >= base + 8)
         chk("stream_spacing", pop_cyc[base+7] - pop_cyc[base], 64'd7);

      // Stall with OUT_READY=0, then drain in order
      OUT_READY = 1'b0;
      step();
      send(32'h11, 24'h000001);
`ifdef PR_SKID_STAGE_SKID_EN
      send(32'h12, 24'h000002);
      IN_VALID = 1'b1; IN_DATA = 32'h13; IN_CTRL = 24'h000003;
      @(negedge CLK);
      chk("stall_ready", {63'd0, IN_READY}, 64'd0);
      chk("stall_occ", {62'd0, OCCUPANCY}, 64'd2);
      step();
      @(negedge CLK);
      chk("stall_ready_hold", {63'd0, IN_READY}, 64'd0);
      step();
      OUT_READY = 1'b1;
      #1 chk("ready_registered", {63'd0, IN_READY}, 64'd0);
      send(32'h13, 24'h000003);
`else
      IN_VALID = 1'b1; IN_DATA = 32'h12; IN_CTRL = 24'h000002;
      @(negedge CLK);
      chk("stall_ready", {63'd0, IN_READY}, 64'd0);
      chk("stall_occ", {62'd0, OCCUPANCY}, 64'd1);
      step();
      @(negedge CLK);
      chk("stall_ready_hold", {63'd0, IN_READY}, 64'd0);
      step();
      OUT_READY = 1'b1;
      #1 chk("ready_comb", {63'd0, IN_READY}, 64'd1);
      send(32'h12, 24'h000002);
      send(32'h13, 24'h000003);
`endif
      step(); step(); step();
      chk("stall_drained", sb.size(), 64'd0);

      // Flush with concurrent offer
      OUT_READY = 1'b0;
      send(32'h21, 24'hFFFFFF);
`ifdef PR_SKID_STAGE_SKID_EN
      send(32'h22, 24'hFFFFFF);
      @(negedge CLK);
      chk("pre_flush_occ", {62'd0, OCCUPANCY}, 64'd2);
      step();
`endif
      FLUSH = 1'b1; IN_VALID = 1'b1; IN_DATA = 32'h99; IN_CTRL = 24'hFFFFFF;
      sb.delete();
      step();
      FLUSH = 1'b0; IN_VALID = 1'b0;
      @(negedge CLK);
      chk("flush_out_valid", {63'd0, OUT_VALID}, 64'd0);
      chk("flush_out_ctrl", {40'd0, OUT_CTRL}, 64'd0);
      chk("flush_occ", {62'd0, OCCUPANCY}, 64'd0);
      step();
      OUT_READY = 1'b1;
      step(); step(); step();

      // Asynchronous reset while holding words
      OUT_READY = 1'b0;
      send(32'h31, 24'h0000AA);
`ifdef PR_SKID_STAGE_SKID_EN
      send(32'h32, 24'h0000BB);
`endif
      #2 RESET = 1'b1;
      sb.delete();
      #1;
      chk("arst_out_valid", {63'd0, OUT_VALID}, 64'd0);
      chk("arst_out_data", {32'd0, OUT_DATA}, 64'd0);
      chk("arst_out_ctrl", {40'd0, OUT_CTRL}, 64'd0);
      chk("arst_occ", {62'd0, OCCUPANCY}, 64'd0);
      chk("arst_in_ready", {63'd0, IN_READY}, 64'd0);
      step();
      #3 RESET = 1'b0;
      OUT_READY = 1'b1;
      step(); step(); step();
      @(negedge CLK);
      chk("post_rst_ready", {63'd0, IN_READY}, 64'd1);
      chk("final_drain", sb.size(), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pr_skid_stage.md
PR_SKID_STAGE -- requirements
Module: pr_skid_stage

Interface
REQ-001 Parameter DATA_WIDTH, default 32, meaning payload width carried unmodified through the stage.
REQ-002 Parameter CTRL_WIDTH, default 24, meaning control-field width, forced to zero on flush and reset.
REQ-003 CLK  input  1  the single clock; all state updates on its rising edge.
REQ-004 RESET  input  1  asynchronous, active-high reset.
REQ-005 FLUSH  input  1  synchronous kill of every held entry.
REQ-006 IN_VALID  input  1  upstream has a word.
REQ-007 IN_READY  output  1  stage accepts a word this cycle.
REQ-008 IN_DATA  input  DATA_WIDTH  upstream payload.
REQ-009 IN_CTRL  input  CTRL_WIDTH  upstream control bits.
REQ-010 OUT_VALID  output  1  OUT_DATA/OUT_CTRL hold a live word.
REQ-011 OUT_READY  input  1  downstream consumes this cycle.
REQ-012 OUT_DATA  output  DATA_WIDTH  head payload.
REQ-013 OUT_CTRL  output  CTRL_WIDTH  head control bits, all-zero when OUT_VALID=0.
REQ-014 OCCUPANCY  output  2  number of held words (0..2).

Function
REQ-015 The stage SHALL accept a word when IN_VALID && IN_READY are both high at a rising edge, and transfer a word out when OUT_VALID && OUT_READY are both high.
REQ-016 Latency SHALL be one cycle: a word accepted into an empty stage appears on OUT_* the next cycle.
REQ-017 States SHALL be EMPTY (occ 0), BUSY (main register valid, occ 1), FULL (main + skid valid, occ 2).
REQ-018 EMPTY: accept -> BUSY; else stay.
REQ-019 BUSY: accept and output -> BUSY with main loaded from input; accept without output -> FULL, input into skid; output without accept -> EMPTY; neither -> stay.
REQ-020 FULL: output -> BUSY with skid moved into main; no input accepted in FULL.
REQ-021 IN_READY SHALL be a registered signal, high in EMPTY and BUSY, low in FULL, with no combinational path from OUT_READY.
REQ-022 Word order SHALL be preserved; no word duplicated or dropped except by FLUSH.
REQ-023 FLUSH high at an edge SHALL force EMPTY, zero all control fields, and discard any concurrently offered input; the input handshake is not counted as an accept; it has priority over every other event.
REQ-024 Payload registers SHALL NOT be cleared by FLUSH (only valid and control), so unused data bits may retain stale values.
REQ-025 OUT_CTRL SHALL be gated to zero whenever OUT_VALID is low, so the downstream stage sees a bubble (no write enable, no memory access).

Reset
REQ-026 RESET high SHALL immediately (asynchronously) force EMPTY, OUT_VALID=0, IN_READY=0, OUT_CTRL=0, OUT_DATA=0, OCCUPANCY=0.
REQ-027 IN_READY SHALL rise on the first clock edge after RESET deasserts.
REQ-028 RESET mid-transfer SHALL lose all held words without emitting them.

Configuration
REQ-029 Macro PR_SKID_STAGE_SKID_EN: defined -> behaviour per REQ-017..021.
REQ-030 Undefined -> no skid register, states EMPTY/BUSY only, IN_READY = !OUT_VALID || OUT_READY (combinational), OCCUPANCY never exceeds 1; all other requirements unchanged.

Structure
REQ-031 State encoding (EMPTY/BUSY/FULL) and the default widths SHALL live in the shared pipeline-register package.
REQ-032 One sub-module, pr_skid_slot (valid + ctrl + data register with load/clear), SHALL be instantiated for main and skid entries.

Verification
REQ-033 Reset then IN_VALID=1 with data 0xA5, OUT_READY=1 -> OUT_VALID=1, OUT_DATA=0xA5 one cycle later, OCCUPANCY=1.
REQ-034 Back-to-back stream 1..8 with OUT_READY=1 -> outputs 1..8 in consecutive cycles, IN_READY never low.
REQ-035 Send 1,2,3 with OUT_READY=0 -> OCCUPANCY=2, IN_READY=0 after second word, word 3 held upstream; raise OUT_READY -> outputs 1,2,3 in order.
REQ-036 FULL with ctrl 0xFFFFFF, FLUSH=1 and IN_VALID=1 same cycle -> next cycle OUT_VALID=0, OUT_CTRL=0, OCCUPANCY=0, offered word absent from output.
REQ-037 RESET asserted between clock edges while FULL -> outputs zero before the next edge; no held word ever appears.
REQ-038 Macro undefined: OUT_VALID=1, OUT_READY=0 -> IN_READY=0; OUT_READY=1 same cycle -> IN_READY=1 combinationally, new word loaded next edge.
